seg7_scan: RTL and testbench

- Downstream display stage for the binary-to-BCD converter.
- Takes the converter's carry/overflow flag and six BCD digits and drives a time-multiplexed, common-anode 8-position seven-segment display.
- Double-buffers input digits so the display only changes at frame boundaries, blanks leading zeros, and flags non-BCD nibbles.

---
 rtl/seg7_scan.sv | 96 +++++++++
 tb/tb_seg7_scan.sv | 138 +++++++++++++
 2 files changed

// File: rtl/seg7_scan.sv
// Time-multiplexed driver for an 8-position common-anode seven-segment display.
// Digits are double-buffered so a new value only appears at a frame boundary.
module seg7_scan #(
   parameter logic [15:0] DIV = 16'd50000
) (
   input  logic       clk,
   input  logic       clr_n,
   input  logic       upd,
   input  logic       ovf,
   input  logic [3:0] d1,
   input  logic [3:0] d2,
   input  logic [3:0] d3,
   input  logic [3:0] d4,
   input  logic [3:0] d5,
   input  logic [3:0] d6,
   output logic [7:0] an,
   output logic [7:0] seg
);

   function automatic logic [6:0] enc7(input logic [3:0] n);
      case (n)
         4'd0:    enc7 = 7'h40;
         4'd1:    enc7 = 7'h79;
         4'd2:    enc7 = 7'h24;
         4'd3:    enc7 = 7'h30;
         4'd4:    enc7 = 7'h19;
         4'd5:    enc7 = 7'h12;
         4'd6:    enc7 = 7'h02;
         4'd7:    enc7 = 7'h78;
         4'd8:    enc7 = 7'h00;
         4'd9:    enc7 = 7'h10;
         default: enc7 = 7'h3F;
      endcase
   endfunction

   // Frame layout: {ovf, d1..d6}; position p digit lives at bits [4p+3:4p].
   function automatic logic [7:0] pos_seg(input logic [24:0] f, input logic [2:0] p);
      logic       blank;
      logic [3:0] dig;
      pos_seg = 8'hFF;
      blank   = ~f[24];
      if (p == 3'd6) begin
         pos_seg = {1'b1, f[24] ? 7'h79 : 7'h7F};
      end else if (p != 3'd7) begin
         // Walk from the most significant digit down; any nonzero nibble ends blanking.
         for (int k = 5; k >= 0; k--) begin
            dig = f[4*k +: 4];
            if (dig != 4'd0) blank = 1'b0;
            if (k == int'(p)) pos_seg = {1'b1, (blank && k != 0) ? 7'h7F : enc7(dig)};
         end
      end
   endfunction

   logic [15:0] cnt;
   logic [2:0]  idx;
   logic        vld_p0;
   logic [24:0] stage_p0;
   logic [24:0] disp_p1;

   logic        tick;
   logic        boundary;
   logic [2:0]  idx_nx;
   logic [24:0] disp_nx;

   always_comb begin
      tick     = (cnt == DIV - 16'd1);
      boundary = tick && (idx == 3'd7);
      idx_nx   = idx + 3'd1;
      disp_nx  = (boundary && vld_p0) ? stage_p0 : disp_p1;
   end

   always_ff @(posedge clk) begin
      if (!clr_n) begin
         cnt      <= '0;
         idx      <= 3'd7;
         vld_p0   <= 1'b0;
         stage_p0 <= '0;
         disp_p1  <= '0;
         an       <= 8'hFF;
         seg      <= 8'hFF;
      end else begin
         cnt <= tick ? 16'd0 : cnt + 16'd1;
         // stage 0: staging register, last strobe before the boundary wins
         if (upd) stage_p0 <= {ovf, d1, d2, d3, d4, d5, d6};
         vld_p0 <= upd | (vld_p0 & ~boundary);
         // stage 1: displayed frame and registered pin drive
         if (tick) begin
            idx     <= idx_nx;
            disp_p1 <= disp_nx;
            an      <= (idx_nx == 3'd7) ? 8'hFF : ~(8'h01 << idx_nx);
            seg     <= pos_seg(disp_nx, idx_nx);
         end
      end
   end

endmodule

// File: tb/tb_seg7_scan.sv
// Directed bench for seg7_scan: table of display values plus staging and reset corner cases.
module tb_seg7_scan;
   localparam int DIV = 4;

   logic       clk = 1'b0;
   logic       clr_n, upd, ovf;
   logic [3:0] d1, d2, d3, d4, d5, d6;
   logic [7:0] an, seg;

   int checks   = 0;
   int failures = 0;
   int slot;
   int used;

   typedef struct {
      logic        ovf;
      logic [23:0] digs;   // {d1,d2,d3,d4,d5,d6}
      logic [63:0] exp;    // {pos7,...,pos0} seg values
   } vec_t;

   vec_t vecs [6];

   seg7_scan #(.DIV(16'(DIV))) dut (
      .clk(clk), .clr_n(clr_n), .upd(upd), .ovf(ovf),
      .d1(d1), .d2(d2), .d3(d3), .d4(d4), .d5(d5), .d6(d6),
      .an(an), .seg(seg)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic set_in(input logic o, input logic [23:0] dg);
      ovf = o;
      {d1, d2, d3, d4, d5, d6} = dg;
   endtask

   task automatic upd_pulse(input logic o, input logic [23:0] dg);
      set_in(o, dg);
      upd = 1'b1;
      @(negedge clk);
      upd = 1'b0;
      used++;
   endtask

   task automatic next_slot(input logic [7:0] es, input string nm);
      repeat (DIV - used) @(negedge clk);
      used = 0;
      slot = (slot + 1) % 8;
      chk($sformatf("%s an slot%0d", nm, slot), an, (slot == 7) ? 8'hFF : ~(8'h01 << slot));
      chk($sformatf("%s seg slot%0d", nm, slot), seg, es);
   endtask

   task automatic rest_frame(input logic [63:0] e, input string nm);
      for (int s = 1; s < 8; s++) next_slot(e[8*s +: 8], nm);
   endtask

   initial begin
      logic [63:0] prev;
      vecs[0] = '{1'b0, 24'h001234, 64'hFFFF_FFFF_F9A4_B099};
      vecs[1] = '{1'b1, 24'h000005, 64'hFFF9_C0C0_C0C0_C092};
      vecs[2] = '{1'b0, 24'h00C007, 64'hFFFF_FFFF_BFC0_C0F8};
      vecs[3] = '{1'b0, 24'h987650, 64'hFFFF_9080_F882_92C0};
      vecs[4] = '{1'b0, 24'h000000, 64'hFFFF_FFFF_FFFF_FFC0};
      vecs[5] = '{1'b0, 24'hF00000, 64'hFFFF_BFC0_C0C0_C0C0};

      clr_n = 1'b0;
      upd   = 1'b0;
      set_in(1'b0, 24'h0);
      slot  = 7;
      used  = 0;
      repeat (3) @(negedge clk);
      chk("reset an", an, 8'hFF);
      chk("reset seg", seg, 8'hFF);

      clr_n = 1'b1;
      repeat (DIV - 1) @(negedge clk);
      chk("pre-first-tick an", an, 8'hFF);
      used = DIV - 1;
      next_slot(8'hC0, "first");
      prev = 64'hFFFF_FFFF_FFFF_FFC0;

      // Each update lands mid-frame: rest of the old frame unchanged, new value from slot 0.
      for (int v = 0; v < 6; v++) begin
         upd_pulse(vecs[v].ovf, vecs[v].digs);
         rest_frame(prev, $sformatf("old%0d", v));
         next_slot(vecs[v].exp[7:0], $sformatf("new%0d", v));
         prev = vecs[v].exp;
      end
      rest_frame(prev, "last");
      next_slot(prev[7:0], "last");

      // Two strobes in one frame: only the second is shown.
      upd_pulse(vecs[0].ovf, vecs[0].digs);
      upd_pulse(vecs[1].ovf, vecs[1].digs);
      rest_frame(prev, "race1 old");
      next_slot(vecs[1].exp[7:0], "race1 new");
      rest_frame(vecs[1].exp, "race1 new");

      // Strobe coincident with the boundary: old stage now, new value one frame later.
      upd_pulse(vecs[3].ovf, vecs[3].digs);
      repeat (DIV - 2) @(negedge clk);
      used = DIV - 1;
      upd_pulse(vecs[2].ovf, vecs[2].digs);
      chk("race2 boundary seg", seg, vecs[3].exp[7:0]);
      slot = 0;
      used = 0;
      rest_frame(vecs[3].exp, "race2 A");
      next_slot(vecs[2].exp[7:0], "race2 B");
      rest_frame(vecs[2].exp, "race2 B");

      // Reset in the middle of a scan with an update pending.
      next_slot(vecs[2].exp[7:0], "pre-rst");
      upd_pulse(vecs[0].ovf, vecs[0].digs);
      next_slot(vecs[2].exp[15:8], "pre-rst");
      next_slot(vecs[2].exp[23:16], "pre-rst");
      next_slot(vecs[2].exp[31:24], "pre-rst");
      clr_n = 1'b0;
      @(negedge clk);
      clr_n = 1'b1;
      chk("midscan reset an", an, 8'hFF);
      chk("midscan reset seg", seg, 8'hFF);
      slot = 7;
      used = 0;
      next_slot(8'hC0, "post-rst");
      rest_frame(64'hFFFF_FFFF_FFFF_FFC0, "post-rst");
      next_slot(8'hC0, "post-rst2");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
